// File: rtl/mem_bus_responder.sv
// mem_bus_responder
//   Responder side of the CPU byte-wide memory bus. It serves a byte-addressed
//   RAM and a small memory-mapped I/O window that contains a TX byte FIFO
//   (CPU to host) and an RX byte FIFO (host to CPU). The CPU issues one byte
//   access per cycle and samples the read data one cycle later.
//
// Ports
//   clk_in       system clock, all state updates on the rising edge
//   rst_in       asynchronous active-low reset
//   rdy_in       when low, all state (RAM, FIFOs, flags, read data) is frozen
//   cpu_addr_i   byte address from the CPU; only bits 17:0 are decoded
//   cpu_wr_i     1 = write, 0 = read (every ready, non-write cycle is a read)
//   cpu_wdata_i  write data from the CPU
//   cpu_rdata_o  registered read data, valid the cycle after the address
//   tx_data_o    TX FIFO head byte
//   tx_valid_o   TX FIFO non-empty
//   tx_ready_i   host accepts tx_data_o when tx_valid_o & tx_ready_i
//   rx_data_i    host byte for the RX FIFO
//   rx_valid_i   host offers rx_data_i
//   rx_ready_o   RX FIFO not full; push when rx_valid_i & rx_ready_o
//
// I/O window: IO_BASE+0 is data (write pushes TX, read pops RX), IO_BASE+4
// is status {5'b0, tx_ovf, tx_full, rx_nonempty} (any write clears tx_ovf),
// and any other address at or above IO_BASE reads as zero and ignores writes.

module mem_bus_responder #(
  parameter int          RAM_ADDR_W = 17,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] IO_BASE    = 32'h0003_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] cpu_addr_i,
  input  logic        cpu_wr_i,
  input  logic [7:0]  cpu_wdata_i,
  output logic [7:0]  cpu_rdata_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [17:0] IO_DATA_ADDR = IO_BASE[17:0];
  localparam logic [17:0] IO_STAT_ADDR = IO_BASE[17:0] + 18'd4;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_DATA = 2'd1,
    REG_STAT = 2'd2,
    REG_NULL = 2'd3
  } region_e;

  logic [7:0]       ram_r [2**RAM_ADDR_W];
  logic [7:0]       tx_mem_r [FIFO_DEPTH];
  logic [7:0]       rx_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] tx_wr_ptr_r, tx_rd_ptr_r, rx_wr_ptr_r, rx_rd_ptr_r;
  logic [CNT_W-1:0] tx_count_r, rx_count_r;
  logic             tx_ovf_r;
  logic [7:0]       cpu_rdata_r;

  logic [17:0]           addr_s;
  logic [RAM_ADDR_W-1:0] ram_idx_s;
  region_e               region_s;
  logic                  live_s;
  logic                  tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
  logic                  tx_push_req_s, tx_push_s, tx_pop_s;
  logic                  tx_ovf_set_s, tx_ovf_clr_s;
  logic                  rx_push_s, rx_pop_s, ram_we_s;
  logic [7:0]            rdata_next_s;
  logic                  unused_addr_s;

  assign addr_s        = cpu_addr_i[17:0];
  assign ram_idx_s     = addr_s[RAM_ADDR_W-1:0];
  assign unused_addr_s = ^cpu_addr_i[31:18];

  // Nothing may complete while stalled or while reset is held.
  assign live_s = rdy_in & rst_in;

  assign tx_full_s  = (tx_count_r == CNT_FULL);
  assign tx_empty_s = (tx_count_r == CNT_ZERO);
  assign rx_full_s  = (rx_count_r == CNT_FULL);
  assign rx_empty_s = (rx_count_r == CNT_ZERO);

  // Address decode into RAM or one of the I/O window slots.
  always_comb begin
    region_s = REG_RAM;
    if (addr_s == IO_DATA_ADDR) begin
      region_s = REG_DATA;
    end else if (addr_s == IO_STAT_ADDR) begin
      region_s = REG_STAT;
    end else if (addr_s >= IO_DATA_ADDR) begin
      region_s = REG_NULL;
    end else begin
      region_s = REG_RAM;
    end
  end

  // A push into a full TX FIFO still succeeds when the host drains the head on
  // the same edge; only an unmatched push into a full FIFO is an overflow.
  assign tx_pop_s      = live_s & tx_ready_i & ~tx_empty_s;
  assign tx_push_req_s = live_s & cpu_wr_i & (region_s == REG_DATA);
  assign tx_push_s     = tx_push_req_s & (~tx_full_s | tx_pop_s);
  assign tx_ovf_set_s  = tx_push_req_s & tx_full_s & ~tx_pop_s;
  assign tx_ovf_clr_s  = live_s & cpu_wr_i & (region_s == REG_STAT);
  assign rx_push_s     = live_s & rx_valid_i & ~rx_full_s;
  assign rx_pop_s      = live_s & ~cpu_wr_i & (region_s == REG_DATA) & ~rx_empty_s;
  assign ram_we_s      = live_s & cpu_wr_i & (region_s == REG_RAM);

  // Read data selection from pre-edge state; holds on writes and stalls.
  always_comb begin
    rdata_next_s = cpu_rdata_r;
    if (rdy_in && !cpu_wr_i) begin
      case (region_s)
        REG_RAM:  rdata_next_s = ram_r[ram_idx_s];
        REG_DATA: rdata_next_s = rx_empty_s ? 8'h00 : rx_mem_r[rx_rd_ptr_r];
        REG_STAT: rdata_next_s = {5'b00000, tx_ovf_r, tx_full_s, ~rx_empty_s};
        REG_NULL: rdata_next_s = 8'h00;
        default:  rdata_next_s = 8'h00;
      endcase
    end else begin
      rdata_next_s = cpu_rdata_r;
    end
  end

  // Storage arrays: RAM and FIFO bodies carry no reset.
  always_ff @(posedge clk_in) begin
    if (ram_we_s) begin
      ram_r[ram_idx_s] <= cpu_wdata_i;
    end
    if (tx_push_s) begin
      tx_mem_r[tx_wr_ptr_r] <= cpu_wdata_i;
    end
    if (rx_push_s) begin
      rx_mem_r[rx_wr_ptr_r] <= rx_data_i;
    end
  end

  // FIFO pointers, counts, overflow flag and registered read data.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      tx_wr_ptr_r <= {PTR_W{1'b0}};
      tx_rd_ptr_r <= {PTR_W{1'b0}};
      rx_wr_ptr_r <= {PTR_W{1'b0}};
      rx_rd_ptr_r <= {PTR_W{1'b0}};
      tx_count_r  <= CNT_ZERO;
      rx_count_r  <= CNT_ZERO;
      tx_ovf_r    <= 1'b0;
      cpu_rdata_r <= 8'h00;
    end else if (rdy_in) begin
      cpu_rdata_r <= rdata_next_s;
      if (tx_push_s) tx_wr_ptr_r <= tx_wr_ptr_r + PTR_ONE;
      if (tx_pop_s)  tx_rd_ptr_r <= tx_rd_ptr_r + PTR_ONE;
      if (rx_push_s) rx_wr_ptr_r <= rx_wr_ptr_r + PTR_ONE;
      if (rx_pop_s)  rx_rd_ptr_r <= rx_rd_ptr_r + PTR_ONE;
      if (tx_push_s && !tx_pop_s) begin
        tx_count_r <= tx_count_r + CNT_ONE;
      end else if (!tx_push_s && tx_pop_s) begin
        tx_count_r <= tx_count_r - CNT_ONE;
      end
      if (rx_push_s && !rx_pop_s) begin
        rx_count_r <= rx_count_r + CNT_ONE;
      end else if (!rx_push_s && rx_pop_s) begin
        rx_count_r <= rx_count_r - CNT_ONE;
      end
      // A new overflow beats a clear on the same edge.
      if (tx_ovf_set_s) begin
        tx_ovf_r <= 1'b1;
      end else if (tx_ovf_clr_s) begin
        tx_ovf_r <= 1'b0;
      end
    end
  end

  assign cpu_rdata_o = cpu_rdata_r;
  assign tx_data_o   = tx_mem_r[tx_rd_ptr_r];
  assign tx_valid_o  = ~tx_empty_s;
  assign rx_ready_o  = ~rx_full_s;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder. A queue-based model of the RAM, the
// two FIFOs and the overflow flag tracks what the outputs must be; a compare
// process checks the DUT against it on every falling edge, and literal
// expectations at key points pin the model itself.

module tb_mem_bus_responder;

  localparam int          FD     = 8;
  localparam int          RAW    = 17;
  localparam logic [31:0] DATA_A = 32'h0003_0000;
  localparam logic [31:0] STAT_A = 32'h0003_0004;
  localparam logic [31:0] NULL_A = 32'h0003_0008;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, cpu_wr_i, tx_ready_i, rx_valid_i;
  logic [31:0] cpu_addr_i;
  logic [7:0]  cpu_wdata_i, rx_data_i;
  logic [7:0]  cpu_rdata_o, tx_data_o;
  logic        tx_valid_o, rx_ready_o;

  int checks   = 0;
  int failures = 0;

  mem_bus_responder #(.RAM_ADDR_W(RAW), .FIFO_DEPTH(FD), .IO_BASE(32'h0003_0000)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .cpu_addr_i(cpu_addr_i), .cpu_wr_i(cpu_wr_i), .cpu_wdata_i(cpu_wdata_i),
    .cpu_rdata_o(cpu_rdata_o), .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o),
    .tx_ready_i(tx_ready_i), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .rx_ready_o(rx_ready_o)
  );

  always #5 clk_in = ~clk_in;

  // ---------------- behavioural model ----------------
  logic [7:0] ram_m [int];
  logic [7:0] txq [$];
  logic [7:0] rxq [$];
  bit         ovf_m    = 1'b0;
  logic [7:0] exp_rd   = 8'h00;
  bit         rd_known = 1'b1;

  task automatic model_step();
    logic [17:0] a;
    bit tp, rp, push_ok;
    int idx;
    a       = cpu_addr_i[17:0];
    idx     = int'(a) % (1 << RAW);
    tp      = tx_ready_i && (txq.size() > 0);
    rp      = rx_valid_i && (rxq.size() < FD);
    push_ok = (txq.size() < FD) || tp;
    if (!cpu_wr_i) begin
      if (a == DATA_A[17:0]) begin
        if (rxq.size() > 0) exp_rd = rxq.pop_front();
        else                exp_rd = 8'h00;
        rd_known = 1'b1;
      end else if (a == STAT_A[17:0]) begin
        exp_rd   = {5'b0, ovf_m, txq.size() == FD, rxq.size() != 0};
        rd_known = 1'b1;
      end else if (a >= DATA_A[17:0]) begin
        exp_rd   = 8'h00;
        rd_known = 1'b1;
      end else if (ram_m.exists(idx)) begin
        exp_rd   = ram_m[idx];
        rd_known = 1'b1;
      end else begin
        rd_known = 1'b0;
      end
    end
    if (tp) void'(txq.pop_front());
    if (cpu_wr_i) begin
      if (a == DATA_A[17:0]) begin
        if (push_ok) txq.push_back(cpu_wdata_i);
        else         ovf_m = 1'b1;
      end else if (a == STAT_A[17:0]) begin
        ovf_m = 1'b0;
      end else if (a < DATA_A[17:0]) begin
        ram_m[idx] = cpu_wdata_i;
      end
    end
    if (rp) rxq.push_back(rx_data_i);
  endtask

  // Model update on the same edges as the DUT.
  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      txq.delete();
      rxq.delete();
      ovf_m    = 1'b0;
      exp_rd   = 8'h00;
      rd_known = 1'b1;
    end else if (rdy_in) begin
      model_step();
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk_in) begin
    if (rd_known) chk("cmp_rdata", cpu_rdata_o, exp_rd);
    chk("cmp_tx_valid", {7'b0, tx_valid_o}, {7'b0, txq.size() != 0});
    if (txq.size() != 0) chk("cmp_tx_data", tx_data_o, txq[0]);
    chk("cmp_rx_ready", {7'b0, rx_ready_o}, {7'b0, rxq.size() < FD});
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk_in);
    #1;
  endtask

  task automatic acc(input bit wr, input logic [31:0] a, input logic [7:0] d);
    cpu_wr_i    = wr;
    cpu_addr_i  = a;
    cpu_wdata_i = d;
    tick();
  endtask

  task automatic idle();
    acc(1'b0, NULL_A, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] got [$];
    rst_in = 1'b0; rdy_in = 1'b1; cpu_wr_i = 1'b0; cpu_addr_i = NULL_A;
    cpu_wdata_i = 8'h00; tx_ready_i = 1'b0; rx_valid_i = 1'b0; rx_data_i = 8'h00;
    #1;
    tick();
    chk("reset_rdata", cpu_rdata_o, 8'h00);
    chk("reset_tx_valid", {7'b0, tx_valid_o}, 8'h00);
    chk("reset_rx_ready", {7'b0, rx_ready_o}, 8'h01);
    rst_in = 1'b1;
    tick();

    // RAM write/read, top RAM address, null window
    acc(1'b1, 32'h0000_0010, 8'hA5);
    acc(1'b0, 32'h0000_0010, 8'h00);
    chk("ram_read", cpu_rdata_o, 8'hA5);
    acc(1'b1, 32'h0002_FFFF, 8'hC3);
    acc(1'b1, NULL_A, 8'h55);
    chk("write_holds_rdata", cpu_rdata_o, 8'hA5);
    acc(1'b0, 32'h0002_FFFF, 8'h00);
    chk("ram_top_read", cpu_rdata_o, 8'hC3);
    acc(1'b0, NULL_A, 8'h00);
    chk("null_read", cpu_rdata_o, 8'h00);

    // TX push 3, then drain
    acc(1'b1, DATA_A, 8'h01);
    acc(1'b1, DATA_A, 8'h02);
    acc(1'b1, DATA_A, 8'h03);
    idle();
    chk("tx_valid_3", {7'b0, tx_valid_o}, 8'h01);
    chk("tx_head_3", tx_data_o, 8'h01);
    tx_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!tx_valid_o) break;
      got.push_back(tx_data_o);
      idle();
    end
    tx_ready_i = 1'b0;
    chk("tx_drain_len", 8'(got.size()), 8'd3);
    if (got.size() == 3) begin
      chk("tx_drain_0", got[0], 8'h01);
      chk("tx_drain_1", got[1], 8'h02);
      chk("tx_drain_2", got[2], 8'h03);
    end

    // Overflow and clear
    for (int i = 0; i <= FD; i++) acc(1'b1, DATA_A, 8'(8'h10 + i));
    acc(1'b0, STAT_A, 8'h00);
    chk("stat_ovf", cpu_rdata_o, 8'h06);
    acc(1'b1, STAT_A, 8'hFF);
    acc(1'b0, STAT_A, 8'h00);
    chk("stat_ovf_clr", cpu_rdata_o, 8'h02);

    // Full + push + pop on the same edge
    tx_ready_i = 1'b1;
    acc(1'b1, DATA_A, 8'hEE);
    tx_ready_i = 1'b0;
    acc(1'b0, STAT_A, 8'h00);
    chk("full_push_pop", cpu_rdata_o, 8'h02);
    chk("full_push_pop_head", tx_data_o, 8'h11);

    // Stall for 3 cycles with every handshake offered
    rdy_in = 1'b0; tx_ready_i = 1'b1; rx_valid_i = 1'b1; rx_data_i = 8'h77;
    acc(1'b1, DATA_A, 8'h99);
    acc(1'b0, DATA_A, 8'h00);
    acc(1'b0, 32'h0000_0010, 8'h00);
    chk("stall_rdata", cpu_rdata_o, 8'h02);
    rdy_in = 1'b1; tx_ready_i = 1'b0; rx_valid_i = 1'b0;
    acc(1'b0, STAT_A, 8'h00);
    chk("stall_stat", cpu_rdata_o, 8'h02);
    chk("stall_head", tx_data_o, 8'h11);

    tx_ready_i = 1'b1;
    repeat (10) idle();
    tx_ready_i = 1'b0;
    chk("tx_empty", {7'b0, tx_valid_o}, 8'h00);

    // RX path
    rx_data_i = 8'h5A; rx_valid_i = 1'b1;
    idle();
    rx_valid_i = 1'b0;
    acc(1'b0, STAT_A, 8'h00);
    chk("rx_stat1", cpu_rdata_o, 8'h01);
    acc(1'b0, DATA_A, 8'h00);
    chk("rx_pop", cpu_rdata_o, 8'h5A);
    acc(1'b0, DATA_A, 8'h00);
    chk("rx_pop_empty", cpu_rdata_o, 8'h00);
    acc(1'b0, STAT_A, 8'h00);
    chk("rx_stat0", cpu_rdata_o, 8'h00);

    // Empty RX: host push and CPU pop on the same edge
    rx_data_i = 8'h33; rx_valid_i = 1'b1;
    acc(1'b0, DATA_A, 8'h00);
    rx_valid_i = 1'b0;
    chk("rx_no_bypass", cpu_rdata_o, 8'h00);
    acc(1'b0, STAT_A, 8'h00);
    chk("rx_after_bypass", cpu_rdata_o, 8'h01);
    acc(1'b0, DATA_A, 8'h00);
    chk("rx_pop_33", cpu_rdata_o, 8'h33);

    // Fill RX, then pop while host keeps offering
    rx_valid_i = 1'b1;
    for (int i = 0; i <= FD; i++) begin
      rx_data_i = 8'(8'h40 + i);
      idle();
    end
    chk("rx_full_ready", {7'b0, rx_ready_o}, 8'h00);
    acc(1'b0, DATA_A, 8'h00);
    chk("rx_full_pop", cpu_rdata_o, 8'h40);
    chk("rx_ready_after_pop", {7'b0, rx_ready_o}, 8'h01);
    rx_valid_i = 1'b0;

    // Reset mid-stream with 4 bytes queued in TX
    for (int i = 0; i < 4; i++) acc(1'b1, DATA_A, 8'(8'hB0 + i));
    acc(1'b0, 32'h0000_0010, 8'h00);
    chk("pre_reset_rdata", cpu_rdata_o, 8'hA5);
    chk("pre_reset_tx_valid", {7'b0, tx_valid_o}, 8'h01);
    rst_in = 1'b0;
    #1;
    chk("async_rst_tx_valid", {7'b0, tx_valid_o}, 8'h00);
    chk("async_rst_rdata", cpu_rdata_o, 8'h00);
    chk("async_rst_rx_ready", {7'b0, rx_ready_o}, 8'h01);
    tick();
    rst_in = 1'b1;
    acc(1'b0, 32'h0000_0010, 8'h00);
    chk("ram_survives_reset", cpu_rdata_o, 8'hA5);
    acc(1'b0, STAT_A, 8'h00);
    chk("stat_after_reset", cpu_rdata_o, 8'h00);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
